sr_latch_bank: RTL

SR_LATCH_BANK -- requirements
Module: sr_latch_bank

---
 rtl/sr_latch_bank.sv | 130 +++++++++++++
 1 files changed

// File: rtl/sr_latch_bank.sv
`default_nettype none
// ============================================================================
//  Module      : sr_latch_bank
//  Description : Bank of independent, clocked set/reset latches. Each channel
//                has selectable set/reset dominance, optional rising-edge
//                qualification of S/R, and a minimum post-set hold time
//                during which reset requests are deferred as "pending".
//  Revision    : 1.0  initial release
// ============================================================================
module sr_latch_bank #(
    parameter int WIDTH        = 8,
    parameter int SET_DOMINANT = 1,
    parameter int EDGE_MODE    = 0,
    parameter int HOLD_CYCLES  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] pend,
    output logic             any
);

    // Reload value of the per-channel hold counter.
    localparam logic [7:0] c_hold    = HOLD_CYCLES[7:0];
    localparam bit         c_set_dom = (SET_DOMINANT != 0);
    localparam bit         c_edge    = (EDGE_MODE != 0);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] r_s_d;        // previous-cycle S, for edge detection
    logic [WIDTH-1:0] r_r_d;        // previous-cycle R, for edge detection
    logic [WIDTH-1:0] r_q;          // latch state
    logic [WIDTH-1:0] r_qbar;       // registered complement of latch state
    logic [WIDTH-1:0] r_rise;       // 0->1 transition pulse
    logic [WIDTH-1:0] r_pend;       // reset deferred by an active hold
    logic [7:0]       r_hc [WIDTH]; // remaining hold cycles per channel

    // ------------------------------------------------------------------------
    // Next-state terms
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] w_s_eff;
    logic [WIDTH-1:0] w_r_eff;
    logic [WIDTH-1:0] w_hold;
    logic [WIDTH-1:0] w_win_set;
    logic [WIDTH-1:0] w_rst_req;
    logic [WIDTH-1:0] w_q_nxt;
    logic [WIDTH-1:0] w_pend_nxt;
    logic [7:0]       w_hc_nxt [WIDTH];

    // In edge mode only a 0->1 change of S/R is a request; otherwise the level is.
    assign w_s_eff = c_edge ? (S & ~r_s_d) : S;
    assign w_r_eff = c_edge ? (R & ~r_r_d) : R;

    // A set loses only when reset-dominant and a reset is requested in the
    // same cycle. With hold active that reset is deferred into pend rather
    // than applied, and the hold is not restarted by the losing set.
    assign w_win_set = w_s_eff & (c_set_dom ? {WIDTH{1'b1}} : ~w_r_eff);

    // A reset is wanted either by a fresh request or by one left pending.
    assign w_rst_req = w_r_eff | r_pend;

    // Hold is active while the channel's counter is nonzero.
    always_comb begin
        w_hold = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_hold[i] = (r_hc[i] != 8'd0);
        end
    end

    // Per-channel latch decision: winning set, deferred reset, or applied reset.
    always_comb begin
        w_q_nxt    = r_q;
        w_pend_nxt = r_pend;
        for (int i = 0; i < WIDTH; i++) begin
            // Counter runs down to zero and stays there unless reloaded.
            w_hc_nxt[i] = w_hold[i] ? (r_hc[i] - 8'd1) : 8'd0;
            if (w_win_set[i]) begin
                w_q_nxt[i]    = 1'b1;
                w_pend_nxt[i] = 1'b0;
                w_hc_nxt[i]   = c_hold;
            end else if (w_rst_req[i]) begin
                if (w_hold[i]) begin
                    // Keep Q high; remember the reset until the hold expires.
                    w_pend_nxt[i] = 1'b1;
                end else begin
                    w_q_nxt[i]    = 1'b0;
                    w_pend_nxt[i] = 1'b0;
                end
            end
        end
    end

    // State registers; reset clears everything including hold and pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_d  <= '0;
            r_r_d  <= '0;
            r_q    <= '0;
            r_qbar <= '1;
            r_rise <= '0;
            r_pend <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_hc[i] <= 8'd0;
            end
        end else begin
            r_s_d  <= S;
            r_r_d  <= R;
            r_q    <= w_q_nxt;
            r_qbar <= ~w_q_nxt;
            r_rise <= w_q_nxt & ~r_q;
            r_pend <= w_pend_nxt;
            for (int i = 0; i < WIDTH; i++) begin
                r_hc[i] <= w_hc_nxt[i];
            end
        end
    end

    assign Q    = r_q;
    assign Qbar = r_qbar;
    assign rise = r_rise;
    assign pend = r_pend;
    assign any  = |r_q;

endmodule
`default_nettype wire
